// File: rtl/tc_sram_mp.sv
// tc_sram_mp: multi-port SRAM model with byte enables and a configurable read latency.
// Each port accepts one read or write per cycle with no backpressure.
// Optional feature macro: TC_SRAM_MP_PARITY_EN adds one even-parity bit per byte lane
// and a per-port parity_err_o output that is valid alongside rvalid_o.
module tc_sram_mp #(
  parameter int unsigned NumWords  = 256,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned NumPorts  = 2,
  parameter int unsigned Latency   = 2,
  parameter int unsigned ReadMode  = 0,
  localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth,
  localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NumPorts-1:0]                  req_i,
  input  logic [NumPorts-1:0]                  we_i,
  input  logic [NumPorts-1:0][AddrWidth-1:0]   addr_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]   wdata_i,
  input  logic [NumPorts-1:0][BeWidth-1:0]     be_i,
  output logic [NumPorts-1:0][DataWidth-1:0]   rdata_o,
  output logic [NumPorts-1:0]                  rvalid_o,
  output logic                                 wconflict_o
`ifdef TC_SRAM_MP_PARITY_EN
  ,
  output logic [NumPorts-1:0]                  parity_err_o
`endif
);

  // Expand per-lane byte enables to a per-bit mask; the last lane may be narrower.
  function automatic logic [DataWidth-1:0] laneMask(input logic [BeWidth-1:0] be);
    logic [DataWidth-1:0] m;
    for (int b = 0; b < DataWidth; b++) begin
      m[b] = be[b / ByteWidth];
    end
    return m;
  endfunction

`ifdef TC_SRAM_MP_PARITY_EN
  // Even parity of every byte lane of a word.
  function automatic logic [BeWidth-1:0] laneParity(input logic [DataWidth-1:0] w);
    logic [BeWidth-1:0] par;
    par = '0;
    for (int b = 0; b < DataWidth; b++) begin
      par[b / ByteWidth] = par[b / ByteWidth] ^ w[b];
    end
    return par;
  endfunction
`endif

  // Storage; deliberately not reset so it maps onto real SRAM macros.
  logic [DataWidth-1:0] mem_q [NumWords];

  logic [NumPorts-1:0]                inRange;
  logic [NumPorts-1:0]                rdEn;
  logic [NumPorts-1:0]                wrEn;
  logic [NumPorts-1:0][DataWidth-1:0] bitMask;
  logic [NumPorts-1:0][DataWidth-1:0] oldWord;
  logic [NumPorts-1:0][DataWidth-1:0] mergedWord;
  logic [NumPorts-1:0][DataWidth-1:0] readWord;
  logic                               conflict;

  logic [Latency-1:0][NumPorts-1:0]                pipeValid_q;
  logic [Latency-1:0][NumPorts-1:0][DataWidth-1:0] pipeData_q;

  logic [NumPorts-1:0][DataWidth-1:0] rdata_d, rdata_q;
  logic [NumPorts-1:0]                rvalid_d, rvalid_q;
  logic                               wconflict_d, wconflict_q;

`ifdef TC_SRAM_MP_PARITY_EN
  logic [BeWidth-1:0]               par_q [NumWords];
  logic [NumPorts-1:0][BeWidth-1:0] oldPar;
  logic [NumPorts-1:0][BeWidth-1:0] mergedPar;
  logic [NumPorts-1:0][BeWidth-1:0] readPar;
  logic [NumPorts-1:0]              parErr;
  logic [Latency-1:0][NumPorts-1:0] pipePerr_q;
  logic [NumPorts-1:0]              perr_d, perr_q;
`endif

  // Decode each port's request; reset masks every request.
  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      inRange[p] = (32'(addr_i[p]) < NumWords);
      rdEn[p]    = !rst_i && req_i[p] && !we_i[p];
      wrEn[p]    = !rst_i && req_i[p] && we_i[p] && inRange[p];
      bitMask[p] = laneMask(be_i[p]);
    end
  end

  // Build, for every port's address, the word as it looks after this cycle's writes.
  // Lanes are applied from the highest port down so the lowest-index writer wins.
  // Every writer to one address therefore stores the same merged word.
  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      oldWord[p]    = inRange[p] ? mem_q[addr_i[p]] : '0;
      mergedWord[p] = oldWord[p];
      for (int q = NumPorts - 1; q >= 0; q--) begin
        if (wrEn[q] && (addr_i[q] == addr_i[p])) begin
          mergedWord[p] = (mergedWord[p] & ~bitMask[q]) | (wdata_i[q] & bitMask[q]);
        end
      end
      readWord[p] = (ReadMode == 1) ? mergedWord[p] : oldWord[p];
    end
  end

  // Flag a write-write collision only when two writers share an address and a lane.
  always_comb begin
    conflict = 1'b0;
    for (int p = 0; p < NumPorts; p++) begin
      for (int q = p + 1; q < NumPorts; q++) begin
        if (wrEn[p] && wrEn[q] && (addr_i[p] == addr_i[q]) && (|(be_i[p] & be_i[q]))) begin
          conflict = 1'b1;
        end
      end
    end
  end

`ifdef TC_SRAM_MP_PARITY_EN
  // Merge parity lanes the same way as data lanes and check the word being read.
  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      oldPar[p]    = inRange[p] ? par_q[addr_i[p]] : '0;
      mergedPar[p] = oldPar[p];
      for (int q = NumPorts - 1; q >= 0; q--) begin
        if (wrEn[q] && (addr_i[q] == addr_i[p])) begin
          mergedPar[p] = (mergedPar[p] & ~be_i[q]) | (laneParity(wdata_i[q]) & be_i[q]);
        end
      end
      readPar[p] = (ReadMode == 1) ? mergedPar[p] : oldPar[p];
      parErr[p]  = |(laneParity(readWord[p]) ^ readPar[p]);
    end
  end
`endif

  // Commit writes at the accepting edge; out-of-range writes never reach here.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NumPorts; p++) begin
      if (wrEn[p]) begin
        mem_q[addr_i[p]] <= mergedWord[p];
`ifdef TC_SRAM_MP_PARITY_EN
        par_q[addr_i[p]] <= mergedPar[p];
`endif
      end
    end
  end

  // Read pipeline: stage 0 captures at the accepting edge, the rest just shift.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipeValid_q <= '0;
      pipeData_q  <= '0;
    end else begin
      pipeValid_q[0] <= rdEn;
      pipeData_q[0]  <= readWord;
      for (int s = 1; s < Latency; s++) begin
        pipeValid_q[s] <= pipeValid_q[s-1];
        pipeData_q[s]  <= pipeData_q[s-1];
      end
    end
  end

`ifdef TC_SRAM_MP_PARITY_EN
  // Parity error flags travel alongside the read data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipePerr_q <= '0;
    end else begin
      pipePerr_q[0] <= parErr & rdEn;
      for (int s = 1; s < Latency; s++) begin
        pipePerr_q[s] <= pipePerr_q[s-1];
      end
    end
  end
`endif

  // Output next-state: read data is held between results, pulses last one cycle.
  always_comb begin
    rvalid_d    = pipeValid_q[Latency-1];
    wconflict_d = conflict;
    rdata_d     = rdata_q;
    for (int p = 0; p < NumPorts; p++) begin
      if (pipeValid_q[Latency-1][p]) begin
        rdata_d[p] = pipeData_q[Latency-1][p];
      end
    end
`ifdef TC_SRAM_MP_PARITY_EN
    perr_d = pipePerr_q[Latency-1] & pipeValid_q[Latency-1];
`endif
  end

  // Output registers, cleared by reset so in-flight reads are discarded.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q     <= '0;
      rvalid_q    <= '0;
      wconflict_q <= 1'b0;
`ifdef TC_SRAM_MP_PARITY_EN
      perr_q      <= '0;
`endif
    end else begin
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      wconflict_q <= wconflict_d;
`ifdef TC_SRAM_MP_PARITY_EN
      perr_q      <= perr_d;
`endif
    end
  end

  assign rdata_o     = rdata_q;
  assign rvalid_o    = rvalid_q;
  assign wconflict_o = wconflict_q;
`ifdef TC_SRAM_MP_PARITY_EN
  assign parity_err_o = perr_q;
`endif

endmodule

// File: tb/tb_tc_sram_mp.sv
// tb_tc_sram_mp: drives two tc_sram_mp instances with identical stimulus.
// dutA: NumWords=256, Latency=2, ReadMode=0 (read-first).
// dutB: NumWords=100, Latency=3, ReadMode=1 (write-first); addresses >= 100 are out of range.
module tb_tc_sram_mp;

  localparam int NP     = 2;
  localparam int DW     = 32;
  localparam int BW     = 4;
  localparam int LatA   = 2;
  localparam int LatB   = 3;
  localparam int WordsA = 256;
  localparam int WordsB = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NP-1:0]         req   = '0;
  logic [NP-1:0]         we    = '0;
  logic [NP-1:0][7:0]    addrA = '0;
  logic [NP-1:0][6:0]    addrB;
  logic [NP-1:0][DW-1:0] wdata = '0;
  logic [NP-1:0][BW-1:0] be    = '0;
  logic [NP-1:0][DW-1:0] rdataA, rdataB;
  logic [NP-1:0]         rvalidA, rvalidB;
  logic                  wconfA, wconfB;
`ifdef TC_SRAM_MP_PARITY_EN
  logic [NP-1:0]         perrA, perrB;
`endif

  // Stimulus keeps every address below 128, so dutB sees the same value.
  assign addrB[0] = addrA[0][6:0];
  assign addrB[1] = addrA[1][6:0];

  always #5 clk = ~clk;

  tc_sram_mp #(
    .NumWords(WordsA), .DataWidth(DW), .ByteWidth(8), .NumPorts(NP), .Latency(LatA), .ReadMode(0)
  ) dutA (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addrA), .wdata_i(wdata),
    .be_i(be), .rdata_o(rdataA), .rvalid_o(rvalidA), .wconflict_o(wconfA)
`ifdef TC_SRAM_MP_PARITY_EN
    , .parity_err_o(perrA)
`endif
  );

  tc_sram_mp #(
    .NumWords(WordsB), .DataWidth(DW), .ByteWidth(8), .NumPorts(NP), .Latency(LatB), .ReadMode(1)
  ) dutB (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addrB), .wdata_i(wdata),
    .be_i(be), .rdata_o(rdataB), .rvalid_o(rvalidB), .wconflict_o(wconfB)
`ifdef TC_SRAM_MP_PARITY_EN
    , .parity_err_o(perrB)
`endif
  );

  typedef struct {
    int          due;
    logic [31:0] data;
  } expEntry_t;
  typedef expEntry_t expQueue_t [$];

  // Scoreboard index is dut*2 + port.
  expQueue_t   scoreQ [4];
  logic [31:0] lastData [4] = '{default: '0};
  logic        expConf [2]  = '{default: 1'b0};
  logic [31:0] modelMem [2][256];
  int          edgeNo = 0;
  int          total  = 0;
  int          bad    = 0;

  // Push expected read results for one dut using the model's current contents.
  task automatic pushReads(input int d);
    expEntry_t e;
    int words;
    words = (d == 0) ? WordsA : WordsB;
    for (int p = 0; p < NP; p++) begin
      if (req[p] && !we[p]) begin
        e.due  = edgeNo + ((d == 0) ? LatA : LatB);
        e.data = (int'(addrA[p]) < words) ? modelMem[d][addrA[p]] : 32'h0;
        scoreQ[d*2+p].push_back(e);
      end
    end
  endtask

  // Reference behaviour at one clock edge: lane-wise writes where the lowest port claims a lane.
  task automatic modelEdge();
    logic claimed;
    int words;
    for (int d = 0; d < 2; d++) begin
      expConf[d] = 1'b0;
      if (!rst) begin
        words = (d == 0) ? WordsA : WordsB;
        if (d == 0) pushReads(d);
        for (int p = 0; p < NP; p++) begin
          if (req[p] && we[p] && (int'(addrA[p]) < words)) begin
            for (int l = 0; l < BW; l++) begin
              if (be[p][l]) begin
                claimed = 1'b0;
                for (int q = 0; q < p; q++) begin
                  if (req[q] && we[q] && (addrA[q] == addrA[p]) && be[q][l]) claimed = 1'b1;
                end
                if (claimed) expConf[d] = 1'b1;
                else modelMem[d][addrA[p]][8*l +: 8] = wdata[p][8*l +: 8];
              end
            end
          end
        end
        if (d == 1) pushReads(d);
      end
    end
  endtask

  // Advance one clock: the model consumes the inputs at the edge, then wait for the falling edge.
  task automatic applyStimulus();
    @(posedge clk);
    edgeNo++;
    modelEdge();
    @(negedge clk);
  endtask

  task automatic setIdle();
    req = '0;
    we  = '0;
    be  = '0;
  endtask

  task automatic setWrite(input int p, input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
    req[p]   = 1'b1;
    we[p]    = 1'b1;
    addrA[p] = a;
    wdata[p] = d;
    be[p]    = b;
  endtask

  task automatic setRead(input int p, input logic [7:0] a);
    req[p]   = 1'b1;
    we[p]    = 1'b0;
    addrA[p] = a;
    be[p]    = '0;
  endtask

  // Monitor: every falling edge, each port must either deliver its due result or hold its last one.
  always @(negedge clk) begin : monitor
    logic [31:0] obsData;
    logic        obsValid;
    logic        obsConf;
    int          idx;
    expEntry_t   e;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < NP; p++) begin
        idx      = d*2 + p;
        obsData  = (d == 0) ? rdataA[p] : rdataB[p];
        obsValid = (d == 0) ? rvalidA[p] : rvalidB[p];
        if (rst) begin
          total++;
          if (obsValid !== 1'b0 || obsData !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_outputs dut%0d port%0d: rvalid=%b rdata=%h, required rvalid=0 rdata=0",
                     d, p, obsValid, obsData);
          end
        end else if (scoreQ[idx].size() > 0 && scoreQ[idx][0].due == edgeNo) begin
          e = scoreQ[idx].pop_front();
          lastData[idx] = e.data;
          total++;
          if (obsValid !== 1'b1 || obsData !== e.data) begin
            bad++;
            $display("[TB] FAIL read_result dut%0d port%0d edge%0d: rvalid=%b rdata=%h, required rvalid=1 rdata=%h",
                     d, p, edgeNo, obsValid, obsData, e.data);
          end
        end else begin
          total++;
          if (obsValid !== 1'b0 || obsData !== lastData[idx]) begin
            bad++;
            $display("[TB] FAIL idle_hold dut%0d port%0d edge%0d: rvalid=%b rdata=%h, required rvalid=0 rdata=%h",
                     d, p, edgeNo, obsValid, obsData, lastData[idx]);
          end
        end
`ifdef TC_SRAM_MP_PARITY_EN
        total++;
        if (((d == 0) ? perrA[p] : perrB[p]) !== 1'b0) begin
          bad++;
          $display("[TB] FAIL parity_err dut%0d port%0d: got 1, required 0", d, p);
        end
`endif
      end
      obsConf = (d == 0) ? wconfA : wconfB;
      total++;
      if (obsConf !== (rst ? 1'b0 : expConf[d])) begin
        bad++;
        $display("[TB] FAIL wconflict dut%0d edge%0d: got %b, required %b", d, edgeNo, obsConf, expConf[d]);
      end
    end
  end

  task automatic test_reset();
    setIdle();
    repeat (3) applyStimulus();
    total++;
    if (rvalidA !== 2'b00 || rdataA !== '0 || wconfA !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_state_A: rvalid=%b rdata=%h wconf=%b, required all zero", rvalidA, rdataA, wconfA);
    end
    total++;
    if (rvalidB !== 2'b00 || rdataB !== '0 || wconfB !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_state_B: rvalid=%b rdata=%h wconf=%b, required all zero", rvalidB, rdataB, wconfB);
    end
    #2 rst = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 64; i++) begin
      setWrite(0, 8'(i), $urandom(), 4'hF);
      setWrite(1, 8'(i + 64), $urandom(), 4'hF);
      applyStimulus();
    end
    setIdle();
    applyStimulus();
  endtask

  task automatic test_latency();
    setWrite(0, 8'd5, 32'hDEADBEEF, 4'hF);
    applyStimulus();
    setIdle();
    setRead(0, 8'd5);
    applyStimulus();
    setIdle();
    applyStimulus();
    total++;
    if (rvalidA[0] !== 1'b0) begin
      bad++;
      $display("[TB] FAIL latency_early_A: rvalid=%b one cycle after read, required 0", rvalidA[0]);
    end
    applyStimulus();
    total++;
    if (rvalidA[0] !== 1'b1 || rdataA[0] !== 32'hDEADBEEF) begin
      bad++;
      $display("[TB] FAIL latency_A: rvalid=%b rdata=%h, required 1 / deadbeef", rvalidA[0], rdataA[0]);
    end
    applyStimulus();
    total++;
    if (rvalidB[0] !== 1'b1 || rdataB[0] !== 32'hDEADBEEF || rvalidA[0] !== 1'b0) begin
      bad++;
      $display("[TB] FAIL latency_B: rvalidB=%b rdataB=%h rvalidA=%b, required 1 / deadbeef / 0",
               rvalidB[0], rdataB[0], rvalidA[0]);
    end
  endtask

  task automatic test_byte_mask();
    setWrite(0, 8'd7, 32'h11223344, 4'hF);
    applyStimulus();
    setWrite(0, 8'd7, 32'hAABBCCDD, 4'h5);
    applyStimulus();
    setWrite(1, 8'd7, 32'h99999999, 4'h0);
    setIdle();
    setWrite(1, 8'd7, 32'h99999999, 4'h0);
    applyStimulus();
    setIdle();
    setRead(1, 8'd7);
    applyStimulus();
    setIdle();
    repeat (2) applyStimulus();
    total++;
    if (rvalidA[1] !== 1'b1 || rdataA[1] !== 32'h11BB33DD) begin
      bad++;
      $display("[TB] FAIL byte_mask_A: rvalid=%b rdata=%h, required 1 / 11bb33dd", rvalidA[1], rdataA[1]);
    end
    applyStimulus();
    total++;
    if (rvalidB[1] !== 1'b1 || rdataB[1] !== 32'h11BB33DD) begin
      bad++;
      $display("[TB] FAIL byte_mask_B: rvalid=%b rdata=%h, required 1 / 11bb33dd", rvalidB[1], rdataB[1]);
    end
  endtask

  task automatic test_read_during_write();
    setWrite(0, 8'd3, 32'h0, 4'hF);
    applyStimulus();
    setWrite(0, 8'd3, 32'hFFFFFFFF, 4'hF);
    setRead(1, 8'd3);
    applyStimulus();
    setIdle();
    setRead(0, 8'd3);
    applyStimulus();
    setIdle();
    applyStimulus();
    total++;
    if (rvalidA[1] !== 1'b1 || rdataA[1] !== 32'h0) begin
      bad++;
      $display("[TB] FAIL rdw_read_first_A: rvalid=%b rdata=%h, required 1 / 00000000", rvalidA[1], rdataA[1]);
    end
    applyStimulus();
    total++;
    if (rvalidB[1] !== 1'b1 || rdataB[1] !== 32'hFFFFFFFF) begin
      bad++;
      $display("[TB] FAIL rdw_write_first_B: rvalid=%b rdata=%h, required 1 / ffffffff", rvalidB[1], rdataB[1]);
    end
    total++;
    if (rvalidA[0] !== 1'b1 || rdataA[0] !== 32'hFFFFFFFF) begin
      bad++;
      $display("[TB] FAIL read_after_write_A: rvalid=%b rdata=%h, required 1 / ffffffff", rvalidA[0], rdataA[0]);
    end
    applyStimulus();
  endtask

  task automatic test_write_collision();
    setWrite(0, 8'd9, 32'hAAAAAAAA, 4'h3);
    setWrite(1, 8'd9, 32'h55555555, 4'hE);
    applyStimulus();
    total++;
    if (wconfA !== 1'b1 || wconfB !== 1'b1) begin
      bad++;
      $display("[TB] FAIL collision_pulse: wconfA=%b wconfB=%b, required 1 / 1", wconfA, wconfB);
    end
    setIdle();
    applyStimulus();
    total++;
    if (wconfA !== 1'b0 || wconfB !== 1'b0) begin
      bad++;
      $display("[TB] FAIL collision_one_cycle: wconfA=%b wconfB=%b, required 0 / 0", wconfA, wconfB);
    end
    setWrite(0, 8'd10, 32'h12345678, 4'h3);
    setWrite(1, 8'd10, 32'h9ABCDEF0, 4'hC);
    applyStimulus();
    total++;
    if (wconfA !== 1'b0 || wconfB !== 1'b0) begin
      bad++;
      $display("[TB] FAIL collision_disjoint: wconfA=%b wconfB=%b, required 0 / 0", wconfA, wconfB);
    end
    setIdle();
    setRead(0, 8'd9);
    setRead(1, 8'd10);
    applyStimulus();
    setIdle();
    repeat (2) applyStimulus();
    total++;
    if (rdataA[0] !== 32'h5555AAAA || rdataA[1] !== 32'h9ABC5678) begin
      bad++;
      $display("[TB] FAIL collision_data_A: rdata0=%h rdata1=%h, required 5555aaaa / 9abc5678",
               rdataA[0], rdataA[1]);
    end
    applyStimulus();
  endtask

  task automatic test_back_to_back();
    int r;
    for (int n = 0; n < 300; n++) begin
      for (int p = 0; p < NP; p++) begin
        r = $urandom_range(0, 3);
        if (r == 0) begin
          req[p] = 1'b0;
          we[p]  = 1'b0;
        end else if (r == 1) begin
          setWrite(p, 8'($urandom_range(0, 15)), $urandom(), 4'($urandom_range(0, 15)));
        end else begin
          setRead(p, 8'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 15)));
        end
      end
      applyStimulus();
    end
    setIdle();
    repeat (4) applyStimulus();
  endtask

  task automatic test_reset_midflight();
    setRead(0, 8'd5);
    setRead(1, 8'd7);
    applyStimulus();
    setRead(0, 8'd9);
    setRead(1, 8'd3);
    applyStimulus();
    setIdle();
    #2 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      scoreQ[i].delete();
      lastData[i] = '0;
    end
    repeat (2) applyStimulus();
    #2 rst = 1'b0;
    repeat (4) applyStimulus();
    total++;
    if (rvalidB !== 2'b00 || rdataB !== '0 || rvalidA !== 2'b00 || rdataA !== '0) begin
      bad++;
      $display("[TB] FAIL reset_discard: rvalidA=%b rdataA=%h rvalidB=%b rdataB=%h, required all zero",
               rvalidA, rdataA, rvalidB, rdataB);
    end
    setRead(0, 8'd5);
    applyStimulus();
    setIdle();
    repeat (3) applyStimulus();
  endtask

  task automatic test_out_of_range();
    setWrite(0, 8'd120, 32'hCAFEF00D, 4'hF);
    applyStimulus();
    setIdle();
    setRead(0, 8'd120);
    applyStimulus();
    setIdle();
    repeat (2) applyStimulus();
    total++;
    if (rvalidA[0] !== 1'b1 || rdataA[0] !== 32'hCAFEF00D) begin
      bad++;
      $display("[TB] FAIL in_range_A: rvalid=%b rdata=%h, required 1 / cafef00d", rvalidA[0], rdataA[0]);
    end
    applyStimulus();
    total++;
    if (rvalidB[0] !== 1'b1 || rdataB[0] !== 32'h0) begin
      bad++;
      $display("[TB] FAIL out_of_range_B: rvalid=%b rdata=%h, required 1 / 00000000", rvalidB[0], rdataB[0]);
    end
    for (int i = 0; i < 50; i++) begin
      setRead(0, 8'(i));
      setRead(1, 8'(i + 50));
      applyStimulus();
    end
    setIdle();
    repeat (4) applyStimulus();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_latency();
    test_byte_mask();
    test_read_during_write();
    test_write_collision();
    test_back_to_back();
    test_reset_midflight();
    test_out_of_range();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
